// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one bus transaction per access through an IDLE/REQ/DONE FSM,
// with lane steering for stores, lane extraction and extension for loads, and alignment faulting.
module mem_stage_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  result_src_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] wdata_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] read_data_m,
  output logic        stall_m,
  output logic        misaligned_m
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        access;
  logic        is_store;
  logic [1:0]  off;
  logic        illegal;
  logic        align_err;
  logic        fault;
  logic        go;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  // Moves the addressed lane down to bit 0, then extends according to the access size.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {24'd0, sh[7:0]};
      3'b101:  load_extend = {16'd0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  assign is_store = mem_write_m;
  assign access   = mem_write_m | (result_src_m == 2'b01);
  assign off      = alu_result_m[1:0];

  always_comb begin
    illegal   = 1'b1;
    align_err = 1'b0;
    be_d      = 4'b0000;
    wdata_d   = 32'd0;
    case (funct3_m)
      3'b000: begin
        illegal = 1'b0;
        be_d    = 4'b0001 << off;
        wdata_d = {4{wdata_m[7:0]}};
      end
      3'b001: begin
        illegal   = 1'b0;
        align_err = off[0];
        be_d      = 4'b0011 << off;
        wdata_d   = {2{wdata_m[15:0]}};
      end
      3'b010: begin
        illegal   = 1'b0;
        align_err = (off != 2'b00);
        be_d      = 4'b1111;
        wdata_d   = wdata_m;
      end
      3'b100: begin
        illegal = is_store;
        be_d    = 4'b0001 << off;
      end
      3'b101: begin
        illegal   = is_store;
        align_err = off[0];
        be_d      = 4'b0011 << off;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign fault        = access & (illegal | align_err);
  assign go           = access & ~fault;
  assign misaligned_m = fault & ~reset;
  assign stall_m      = go & (state_q != DONE) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'b0000;
      rdata_q  <= 32'd0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q  <= REQ;
            req_q    <= 1'b1;
            we_q     <= is_store;
            addr_q   <= {alu_result_m[31:2], 2'b00};
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            funct3_q <= funct3_m;
            off_q    <= off;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            if (!we_q) rdata_q <= load_extend(funct3_q, off_q, dmem_rdata);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign read_data_m = rdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: hand-computed expectations for loads, stores, faults and reset.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  result_src_m;
  logic        mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m;
  logic [31:0] wdata_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data_m;
  logic        stall_m;
  logic        misaligned_m;

  int n_tests = 0;
  int n_fail  = 0;
  int sc, rc;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset),
    .result_src_m(result_src_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
    .alu_result_m(alu_result_m), .wdata_m(wdata_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .read_data_m(read_data_m), .stall_m(stall_m), .misaligned_m(misaligned_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_acc(input logic ws, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    mem_write_m  = ws;
    result_src_m = rs;
    funct3_m     = f3;
    alu_result_m = a;
    wdata_m      = wd;
  endtask

  task automatic clear_acc();
    set_acc(1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    dmem_ready = 1'b0;
  endtask

  // Runs one access from IDLE until stall drops (DONE), counting stall and request cycles;
  // ready is withheld for the first 'delay' request cycles.
  task automatic run(input int delay, output int stall_cnt, output int req_cnt);
    stall_cnt = 0;
    req_cnt   = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stall_m) break;
      stall_cnt++;
      if (dmem_req) begin
        dmem_ready = (req_cnt >= delay);
        req_cnt++;
      end else begin
        dmem_ready = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic next_idle();
    clear_acc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_acc();
    dmem_rdata = 32'd0;

    // Reset: outputs cleared, stall/misaligned masked even with an access present.
    set_acc(1'b0, 2'b01, 3'b010, 32'h100, 32'd0);
    dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_rdata", read_data_m, 0);
    chk("rst_stall", stall_m, 0);
    alu_result_m = 32'h101;
    #1;
    chk("rst_misal", misaligned_m, 0);
    clear_acc();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Ready while idle with no access does nothing.
    dmem_ready = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    chk("idle_ready_req", dmem_req, 0);
    chk("idle_ready_rdata", read_data_m, 0);
    dmem_ready = 1'b0;

    // LW 0x100, ready at once.
    set_acc(1'b0, 2'b01, 3'b010, 32'h100, 32'd0);
    dmem_rdata = 32'hDEAD_BEEF;
    run(0, sc, rc);
    chk("lw_stall_cycles", sc, 2);
    chk("lw_req_cycles", rc, 1);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_be", dmem_be, 4'b1111);
    chk("lw_we", dmem_we, 0);
    chk("lw_rdata", read_data_m, 32'hDEAD_BEEF);
    next_idle();

    // LB / LBU at 0x103.
    set_acc(1'b0, 2'b01, 3'b000, 32'h103, 32'd0);
    dmem_rdata = 32'h80FF_0000;
    run(0, sc, rc);
    chk("lb_be", dmem_be, 4'b1000);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_rdata", read_data_m, 32'hFFFF_FF80);
    next_idle();
    set_acc(1'b0, 2'b01, 3'b100, 32'h103, 32'd0);
    run(0, sc, rc);
    chk("lbu_rdata", read_data_m, 32'h0000_0080);
    next_idle();

    // LH / LHU at 0x102.
    set_acc(1'b0, 2'b01, 3'b001, 32'h102, 32'd0);
    dmem_rdata = 32'h8001_0000;
    run(1, sc, rc);
    chk("lh_be", dmem_be, 4'b1100);
    chk("lh_stall_cycles", sc, 3);
    chk("lh_rdata", read_data_m, 32'hFFFF_8001);
    next_idle();
    set_acc(1'b0, 2'b01, 3'b101, 32'h102, 32'd0);
    run(0, sc, rc);
    chk("lhu_rdata", read_data_m, 32'h0000_8001);
    next_idle();

    // SH 0x202 with ready delayed 3 cycles; loaded value must survive the store.
    set_acc(1'b1, 2'b00, 3'b001, 32'h202, 32'h1234_ABCD);
    dmem_rdata = 32'h5555_5555;
    run(3, sc, rc);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", dmem_we, 1);
    chk("sh_req_cycles", rc, 4);
    chk("sh_stall_cycles", sc, 5);
    chk("sh_rdata_kept", read_data_m, 32'h0000_8001);
    next_idle();

    // LW 0x101 is misaligned: no request, no stall, data unchanged.
    set_acc(1'b0, 2'b01, 3'b010, 32'h101, 32'd0);
    #1;
    chk("misal_flag", misaligned_m, 1);
    chk("misal_stall", stall_m, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("misal_req", dmem_req, 0);
    end
    chk("misal_rdata", read_data_m, 32'h0000_8001);

    // Illegal funct3: store with 100, load with 011.
    set_acc(1'b1, 2'b00, 3'b100, 32'h0, 32'd0);
    #1;
    chk("ill_store_flag", misaligned_m, 1);
    chk("ill_store_stall", stall_m, 0);
    set_acc(1'b0, 2'b01, 3'b011, 32'h0, 32'd0);
    #1;
    chk("ill_load_flag", misaligned_m, 1);
    @(posedge clk);
    #1;
    chk("ill_req", dmem_req, 0);
    next_idle();
    chk("noacc_flag", misaligned_m, 0);

    // Store and load flags together: treated as SB at 0x3.
    set_acc(1'b1, 2'b01, 3'b000, 32'h3, 32'h5A);
    run(0, sc, rc);
    chk("sb_we", dmem_we, 1);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
    chk("sb_rdata_kept", read_data_m, 32'h0000_8001);
    next_idle();

    // Reset in the middle of REQ, then a stray ready.
    set_acc(1'b0, 2'b01, 3'b010, 32'h100, 32'd0);
    dmem_rdata = 32'h1122_3344;
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_req_on", dmem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_rdata", read_data_m, 0);
    chk("mid_rst_stall", stall_m, 0);
    clear_acc();
    @(posedge clk);
    #1;
    reset = 1'b0;
    dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_req", dmem_req, 0);
    end
    chk("post_rst_rdata", read_data_m, 0);
    dmem_ready = 1'b0;
    set_acc(1'b0, 2'b01, 3'b010, 32'h100, 32'd0);
    run(0, sc, rc);
    chk("post_rst_lw_stall", sc, 2);
    chk("post_rst_lw_rdata", read_data_m, 32'h1122_3344);
    next_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data and address.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 result_src_m  input  2  writeback select from the EX/MEM register; 2'b01 denotes a load.
REQ-006 mem_write_m  input  1  store request.
REQ-007 funct3_m  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 alu_result_m  input  32  byte address.
REQ-009 wdata_m  input  32  store data, right-aligned.
REQ-010 dmem_req  output  1  bus request.
REQ-011 dmem_we  output  1  bus write enable.
REQ-012 dmem_addr  output  32  word address, with bits [1:0] forced to 0.
REQ-013 dmem_wdata  output  32  lane-replicated store data.
REQ-014 dmem_be  output  4  byte enables.
REQ-015 dmem_ready  input  1  bus completion, sampled only while dmem_req=1.
REQ-016 dmem_rdata  input  32  bus read word, valid when dmem_ready=1.
REQ-017 read_data_m  output  32  extended load result.
REQ-018 stall_m  output  1  freeze request to the upstream pipeline registers.
REQ-019 misaligned_m  output  1  fault flag for a misaligned access or illegal funct3.

Function
REQ-020 An access SHALL exist when mem_write_m=1 or result_src_m=2'b01; if both are set, the access SHALL be a store.
REQ-021 The FSM SHALL have three states: IDLE, REQ and DONE.
- IDLE -> REQ on a legal access.
- REQ -> DONE on the cycle where dmem_ready=1.
- DONE -> IDLE unconditionally.
REQ-022 On the IDLE->REQ edge, the block SHALL register dmem_addr, dmem_we, dmem_be and dmem_wdata; these SHALL hold constant throughout REQ.
REQ-023 dmem_req SHALL be 1 exactly while the FSM is in REQ.
REQ-024 stall_m SHALL be combinational: 1 when a legal access exists and the state is not DONE, else 0.
REQ-025 Minimum latency SHALL be 3 cycles (IDLE, REQ, DONE), with each dmem_ready=0 cycle in REQ adding one cycle.
REQ-026 Load data SHALL be captured into read_data_m on the REQ->DONE edge and held until the next completed load.
REQ-027 Byte lane selection SHALL use alu_result_m[1:0].
- B/BU: be = 1<<a[1:0].
- H/HU: be = 4'b0011<<a[1:0].
- W: be = 4'b1111.
REQ-028 Store data SHALL be replicated across lanes: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
REQ-029 Loads SHALL shift the selected lane to bit 0, then sign-extend (B, H) or zero-extend (BU, HU); W passes through unchanged.
REQ-030 Misalignment SHALL be defined as H/HU with a[0]=1, W with a[1:0]!=0, or any funct3 outside the legal set (stores: 011, 1xx illegal).
REQ-031 On misalignment: misaligned_m=1 combinationally, no bus request is issued, stall_m=0, read_data_m is unchanged, and the FSM stays in IDLE.
REQ-032 dmem_rdata SHALL be ignored outside REQ; a dmem_ready arriving in IDLE or DONE SHALL have no effect.

Reset
REQ-033 Asserting reset SHALL immediately force the FSM to IDLE and set dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata and read_data_m to 0.
REQ-034 While reset is asserted, stall_m and misaligned_m SHALL be 0.
REQ-035 A reset asserted during REQ SHALL abandon the transaction; any subsequent dmem_ready SHALL be ignored.
REQ-036 After reset deasserts, the first rising clk edge SHALL evaluate the inputs from IDLE.

Verification
REQ-037 LW at 0x100 with ready on the first REQ cycle, dmem_rdata=0xDEADBEEF SHALL give: dmem_addr=0x100, be=1111, stall_m high for 2 cycles, read_data_m=0xDEADBEEF in DONE.
REQ-038 LB at 0x103, dmem_rdata=0x80FF_0000 SHALL give read_data_m=0xFFFFFF80; LBU at the same address SHALL give 0x00000080.
REQ-039 SH at 0x202, wdata_m=0x1234ABCD, with ready delayed 3 cycles SHALL give dmem_addr=0x200, be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, dmem_req held for 4 cycles and stall_m for 5 cycles.
REQ-040 LW at 0x101 SHALL give misaligned_m=1, dmem_req never asserted, stall_m=0, and read_data_m unchanged.
REQ-041 Reset asserted mid-REQ with dmem_ready pulsed afterwards SHALL give dmem_req=0 asynchronously, the FSM in IDLE, and read_data_m=0.
REQ-042 mem_write_m=1 with result_src_m=01, SB at 0x3, wdata_m=0x5A SHALL give dmem_we=1, be=1000, and dmem_wdata=0x5A5A5A5A.
